conv_window_feeder: RTL and testbench

- Sits in front of the 16-tap symmetric Gaussian convolution stage of the laser-line detector.
- Accepts a raster pixel stream one 8-bit sample per cycle. Builds the 16-sample sliding window that stage consumes as data[0:15].
- Tags each full window with its column position and an end-of-line flag, so the downstream peak search can locate the laser line per row.
- Also reports line-length protocol errors.

---
 rtl/conv_window_feeder.sv | 103 ++++++++++
 tb/tb_conv_window_feeder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder.sv
// Sliding 16-sample window builder for the Gaussian line-detector convolution.
// Tags each complete window with its left column and end-of-line; flags line-length errors.
module conv_window_feeder #(
    parameter int DATA_W   = 8,
    parameter int TAPS     = 16,
    parameter int LINE_LEN = 640,
    parameter int COL_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              line_start,
    output logic [DATA_W-1:0] data [0:TAPS-1],
    output logic              win_valid,
    output logic [COL_W-1:0]  win_col,
    output logic              win_last,
    output logic              short_line,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    localparam logic [COL_W-1:0] TAPS_C = COL_W'(TAPS);
    localparam logic [COL_W-1:0] LAST_C = COL_W'(LINE_LEN);
    localparam logic [COL_W-1:0] ONE_C  = COL_W'(1);

    state_t           state, state_nxt;
    logic [COL_W-1:0] col, col_nxt, col_inc;
    logic [COL_W-1:0] col_p0;
    logic             shift_p0, vld_p0, last_p0, short_set, over_set;

    assign col_inc = col + ONE_C;
    assign col_p0  = col_inc - TAPS_C;

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        shift_p0  = 1'b0;
        vld_p0    = 1'b0;
        last_p0   = 1'b0;
        short_set = 1'b0;
        over_set  = 1'b0;
        if (pix_valid) begin
            if (line_start) begin
                // A line start always restarts the count at column 0, even mid-line.
                shift_p0  = 1'b1;
                col_nxt   = ONE_C;
                state_nxt = FILL;
                short_set = (state == FILL) || (state == RUN);
            end else begin
                case (state)
                    FILL: begin
                        shift_p0 = 1'b1;
                        col_nxt  = col_inc;
                        if (col_inc == TAPS_C) begin
                            vld_p0    = 1'b1;
                            state_nxt = RUN;
                        end
                    end
                    RUN: begin
                        shift_p0 = 1'b1;
                        col_nxt  = col_inc;
                        vld_p0   = 1'b1;
                        if (col_inc == LAST_C) begin
                            last_p0   = 1'b1;
                            state_nxt = DONE;
                        end
                    end
                    DONE:    over_set = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Stage p0 -> registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            col        <= '0;
            win_valid  <= 1'b0;
            win_last   <= 1'b0;
            win_col    <= '0;
            short_line <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < TAPS; k++) data[k] <= '0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            win_valid <= vld_p0;
            win_last  <= last_p0;
            if (vld_p0) win_col <= col_p0;
            if (short_set) short_line <= 1'b1;
            if (over_set)  overrun    <= 1'b1;
            if (shift_p0) begin
                for (int k = 0; k < TAPS - 1; k++) data[k] <= data[k+1];
                data[TAPS-1] <= pix_in;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder with a reference model feeding an expectation queue.
module tb_conv_window_feeder;

    localparam int DW   = 8;
    localparam int TAPS = 16;
    localparam int LL   = 640;
    localparam int CW   = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] pix_in;
    logic          pix_valid;
    logic          line_start;
    logic [DW-1:0] data [0:TAPS-1];
    logic          win_valid;
    logic [CW-1:0] win_col;
    logic          win_last;
    logic          short_line;
    logic          overrun;

    conv_window_feeder #(.DATA_W(DW), .TAPS(TAPS), .LINE_LEN(LL), .COL_W(CW)) dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
        .line_start(line_start), .data(data), .win_valid(win_valid),
        .win_col(win_col), .win_last(win_last), .short_line(short_line),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          vld;
        logic [CW-1:0] col;
        logic          last;
        logic          sl;
        logic          ov;
        logic [127:0]  win;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [CW-1:0] last_col;
    logic [127:0]  last_win;

    logic [7:0] mwin [0:TAPS-1];
    int  cnt;
    bit  mdone, msl, mov;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] packd();
        logic [127:0] w;
        for (int k = 0; k < TAPS; k++) w[k*8 +: 8] = data[k];
        return w;
    endfunction

    function automatic logic [127:0] packm();
        logic [127:0] w;
        for (int k = 0; k < TAPS; k++) w[k*8 +: 8] = mwin[k];
        return w;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) mwin[k] = 8'd0;
        cnt = 0; mdone = 0; msl = 0; mov = 0;
        q.delete();
    endtask

    task automatic mshift(input logic [7:0] px);
        for (int k = 0; k < TAPS - 1; k++) mwin[k] = mwin[k+1];
        mwin[TAPS-1] = px;
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = q.pop_front();
        chk("win_valid", win_valid, e.vld);
        chk("window", packd(), e.win);
        chk("short_line", short_line, e.sl);
        chk("overrun", overrun, e.ov);
        chk("win_last", win_last, e.last);
        if (e.vld) chk("win_col", win_col, e.col);
        if (win_valid) begin
            pulses++;
            last_col = win_col;
            last_win = packd();
        end
    endtask

    // Drive one cycle of input, predict the registered result, compare after the edge.
    task automatic drive(input logic pv, input logic ls, input logic [7:0] px);
        exp_t e;
        pix_valid = pv; line_start = ls; pix_in = px;
        e = '0;
        if (pv && ls) begin
            if (cnt > 0 && !mdone) msl = 1;
            mshift(px);
            cnt = 1;
            mdone = 0;
        end else if (pv && cnt > 0 && !mdone) begin
            mshift(px);
            cnt++;
            if (cnt >= TAPS) begin
                e.vld  = 1'b1;
                e.col  = CW'(cnt - TAPS);
                e.last = (cnt == LL);
                if (cnt == LL) mdone = 1;
            end
        end else if (pv && mdone) begin
            mov = 1;
        end
        e.sl = msl; e.ov = mov; e.win = packm();
        q.push_back(e);
        @(posedge clk); #1;
        check_out();
    endtask

    task automatic check_reset_state();
        chk("rst_data", packd(), 128'd0);
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_win_last", win_last, 1'b0);
        chk("rst_win_col", win_col, '0);
        chk("rst_short_line", short_line, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
    endtask

    initial begin
        reset = 1'b1; pix_valid = 1'b0; line_start = 1'b0; pix_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Stray pixels before any line start are dropped
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(i + 33));

        // Full contiguous line
        pulses = 0;
        for (int c = 0; c < LL; c++) drive(1'b1, c == 0, 8'(c));
        chk("full_pulses", 128'(pulses), 128'd625);
        chk("full_last_col", last_col, 10'd624);
        chk("full_last_win0", last_win[7:0], 8'd112);
        chk("full_last_win15", last_win[127:120], 8'd127);
        drive(1'b0, 1'b0, 8'd0);

        // Overrun: pixels without line start after the line completed
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(200 + i));

        // Gapped line, every third cycle idle
        pulses = 0;
        begin
            int c = 0;
            int i = 0;
            while (c < LL) begin
                if (i % 3 == 2) drive(1'b0, 1'b0, 8'hee);
                else begin
                    drive(1'b1, c == 0, 8'(c));
                    c++;
                end
                i++;
            end
        end
        chk("gap_pulses", 128'(pulses), 128'd625);
        chk("gap_last_col", last_col, 10'd624);

        // Short line: restart after 100 pixels
        for (int c = 0; c < 100; c++) drive(1'b1, c == 0, 8'(c ^ 8'h5a));
        pulses = 0;
        for (int c = 0; c < 20; c++) drive(1'b1, c == 0, 8'(c + 1));
        chk("short_pulses", 128'(pulses), 128'd5);
        chk("short_flag", short_line, 1'b1);

        // Asynchronous reset between edges while in RUN
        #3; reset = 1'b1;
        #1;
        check_reset_state();
        model_reset();
        pix_valid = 1'b0; line_start = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 8'd55);
        drive(1'b1, 1'b0, 8'd56);

        // A fresh line after reset fills normally
        for (int c = 0; c < 18; c++) drive(1'b1, c == 0, 8'(c + 9));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
